// File: rtl/acc_arb_if.sv
// -----------------------------------------------------------------------------
// acc_arb_if
// Bundles every signal of the two-requester burst arbiter except clk/reset_n.
//
// Requester side : req_i, len0_i/len1_i, data0_i/data1_i, dvalid_i (in),
//                  dready_o, done_o, result_o, err_o, busy_o (out)
// Accumulator side: acc_reset_n_o, acc_number_o, acc_valid_o, acc_run_o (out),
//                  acc_valid_i, acc_result_i (in)
//
// Modports:
//   slave  - the arbiter's view (acc_arb uses this one)
//   master - the environment's view (requesters + accumulator)
// -----------------------------------------------------------------------------
interface acc_arb_if #(
    parameter int IN_DATA_WIDTH = 8,
    parameter int DWIDTH        = 16,
    parameter int LEN_WIDTH     = 8
);
    logic [1:0]               req_i;
    logic [LEN_WIDTH-1:0]     len0_i;
    logic [LEN_WIDTH-1:0]     len1_i;
    logic [IN_DATA_WIDTH-1:0] data0_i;
    logic [IN_DATA_WIDTH-1:0] data1_i;
    logic [1:0]               dvalid_i;
    logic [1:0]               dready_o;
    logic [1:0]               done_o;
    logic [DWIDTH-1:0]        result_o;
    logic                     err_o;
    logic                     busy_o;
    logic                     acc_reset_n_o;
    logic [IN_DATA_WIDTH-1:0] acc_number_o;
    logic                     acc_valid_o;
    logic                     acc_run_o;
    logic                     acc_valid_i;
    logic [DWIDTH-1:0]        acc_result_i;

    modport slave (
        input  req_i, len0_i, len1_i, data0_i, data1_i, dvalid_i,
        input  acc_valid_i, acc_result_i,
        output dready_o, done_o, result_o, err_o, busy_o,
        output acc_reset_n_o, acc_number_o, acc_valid_o, acc_run_o
    );

    modport master (
        output req_i, len0_i, len1_i, data0_i, data1_i, dvalid_i,
        output acc_valid_i, acc_result_i,
        input  dready_o, done_o, result_o, err_o, busy_o,
        input  acc_reset_n_o, acc_number_o, acc_valid_o, acc_run_o
    );
endinterface

// File: rtl/acc_arb.sv
// -----------------------------------------------------------------------------
// acc_arb
// Round-robin arbiter that grants one of two requesters a burst on a shared
// accumulator. A granted burst clears the accumulator, streams len samples
// into it, waits for one acc_valid_i per sample and reports the captured sum
// with a one-cycle done pulse. A burst whose results stop arriving is closed
// after TIMEOUT cycles of waiting with err_o set.
//
// Ports:
//   clk      - rising-edge clock
//   reset_n  - synchronous active-low reset
//   bus      - acc_arb_if.slave: requester handshake and accumulator control
// -----------------------------------------------------------------------------
module acc_arb #(
    parameter int IN_DATA_WIDTH = 8,
    parameter int DWIDTH        = 16,
    parameter int LEN_WIDTH     = 8,
    parameter int TIMEOUT       = 16
) (
    input  logic     clk,
    input  logic     reset_n,
    acc_arb_if.slave bus
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                 state_q,  state_d;
    logic                   gnt_q,    gnt_d;     // granted requester index
    logic                   ptr_q,    ptr_d;     // last granted requester
    logic [LEN_WIDTH-1:0]   len_q,    len_d;
    logic [LEN_WIDTH-1:0]   sent_q,   sent_d;
    logic [LEN_WIDTH-1:0]   recv_q,   recv_d;
    logic [TW-1:0]          tmr_q,    tmr_d;
    logic [1:0]             done_q,   done_d;
    logic [DWIDTH-1:0]      result_q, result_d;
    logic                   err_q,    err_d;
    logic                   busy_q,   busy_d;

    logic                     pick;
    logic [LEN_WIDTH-1:0]     pick_len;
    logic                     in_stream;
    logic                     in_drain;
    logic                     g_valid;
    logic [IN_DATA_WIDTH-1:0] g_data;
    logic                     xfer;
    logic                     rx;
    logic                     last_sent;
    logic                     last_recv;
    logic                     timeout_hit;

    // Arbitration: a lone request wins outright; on a tie the requester that
    // was not served last wins. ptr resets to 1 so requester 0 wins first.
    always_comb begin
        pick = bus.req_i[1];
        if (bus.req_i == 2'b11) begin
            pick = ~ptr_q;
        end
        pick_len = pick ? bus.len1_i : bus.len0_i;
    end

    assign in_stream   = (state_q == ST_STREAM);
    assign in_drain    = (state_q == ST_DRAIN);
    assign g_valid     = gnt_q ? bus.dvalid_i[1] : bus.dvalid_i[0];
    assign g_data      = gnt_q ? bus.data1_i : bus.data0_i;
    assign xfer        = in_stream & g_valid;
    assign rx          = (in_stream | in_drain) & bus.acc_valid_i;

    // len_q is never zero outside IDLE/DONE, so len_q-1 cannot wrap and a
    // length of all-ones completes with the counters topping out at len-1.
    assign last_sent   = xfer & (sent_q == len_q - LEN_WIDTH'(1));
    assign last_recv   = rx & (recv_q == len_q - LEN_WIDTH'(1));
    assign timeout_hit = in_drain & (tmr_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        ptr_d    = ptr_q;
        len_d    = len_q;
        sent_d   = sent_q;
        recv_d   = recv_q;
        tmr_d    = tmr_q;
        result_d = result_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                if (|bus.req_i) begin
                    gnt_d  = pick;
                    len_d  = pick_len;
                    sent_d = '0;
                    recv_d = '0;
                    tmr_d  = '0;
                    if (pick_len == '0) begin
                        // Empty burst: report an empty sum without touching
                        // the accumulator.
                        state_d  = ST_DONE;
                        result_d = '0;
                        err_d    = 1'b0;
                    end else begin
                        state_d = ST_CLEAR;
                    end
                end
            end

            ST_CLEAR: begin
                state_d = ST_STREAM;
            end

            ST_STREAM: begin
                if (xfer) begin
                    sent_d = sent_q + LEN_WIDTH'(1);
                end
                if (rx) begin
                    recv_d = recv_q + LEN_WIDTH'(1);
                end
                // A same-cycle final result outranks moving on to DRAIN.
                if (last_recv) begin
                    state_d  = ST_DONE;
                    result_d = bus.acc_result_i;
                    err_d    = 1'b0;
                end else if (last_sent) begin
                    state_d = ST_DRAIN;
                    tmr_d   = '0;
                end
            end

            ST_DRAIN: begin
                tmr_d = tmr_q + TW'(1);
                if (rx) begin
                    recv_d = recv_q + LEN_WIDTH'(1);
                end
                if (last_recv) begin
                    state_d  = ST_DONE;
                    result_d = bus.acc_result_i;
                    err_d    = 1'b0;
                end else if (timeout_hit) begin
                    state_d  = ST_DONE;
                    result_d = bus.acc_result_i;
                    err_d    = 1'b1;
                end
            end

            ST_DONE: begin
                ptr_d   = gnt_q;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // done_o and busy_o are registered copies of the next state so they
        // line up exactly with the DONE / non-IDLE cycles.
        done_d = (state_d == ST_DONE) ? {gnt_d, ~gnt_d} : 2'b00;
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            gnt_q    <= 1'b0;
            ptr_q    <= 1'b1;
            len_q    <= '0;
            sent_q   <= '0;
            recv_q   <= '0;
            tmr_q    <= '0;
            done_q   <= 2'b00;
            result_q <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            ptr_q    <= ptr_d;
            len_q    <= len_d;
            sent_q   <= sent_d;
            recv_q   <= recv_d;
            tmr_q    <= tmr_d;
            done_q   <= done_d;
            result_q <= result_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    // Sample path is combinational so a requester sees ready in the same
    // cycle it presents data; only the granted requester ever sees ready.
    assign bus.dready_o      = in_stream ? {gnt_q, ~gnt_q} : 2'b00;
    assign bus.acc_valid_o   = xfer;
    assign bus.acc_number_o  = xfer ? g_data : '0;
    assign bus.acc_run_o     = in_stream | in_drain;
    assign bus.acc_reset_n_o = reset_n & (state_q != ST_CLEAR);

    assign bus.done_o        = done_q;
    assign bus.result_o      = result_q;
    assign bus.err_o         = err_q;
    assign bus.busy_o        = busy_q;

endmodule

// File: tb/tb_acc_arb.sv
module tb_acc_arb;

    typedef struct {
        logic [1:0]  done;
        logic [15:0] res;
        logic        err;
    } exp_t;

    logic clk;
    logic reset_n;

    acc_arb_if #(.IN_DATA_WIDTH(8), .DWIDTH(16), .LEN_WIDTH(8)) bus ();

    acc_arb #(
        .IN_DATA_WIDTH(8),
        .DWIDTH       (16),
        .LEN_WIDTH    (8),
        .TIMEOUT      (16)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    logic [7:0] s0[$];
    logic [7:0] s1[$];
    bit   toggle_en = 0;
    bit   phase = 0;
    int   cyc = 0;
    int   last_done_cyc = 0;
    int   clr_cnt = 0;
    int   drain_cnt = 0;
    bit   dr1_seen = 0;

    // Accumulator model: one cycle after each accepted sample it presents the
    // updated sum with a valid pulse; optionally drops the pulse of sample N.
    logic [15:0] acc_sum;
    int          acc_cnt;
    bit          drop_en = 0;
    int          drop_idx = 0;

    assign bus.acc_result_i = acc_sum;

    always @(posedge clk) begin
        if (!bus.acc_reset_n_o) begin
            acc_sum         <= 16'd0;
            acc_cnt         <= 0;
            bus.acc_valid_i <= 1'b0;
        end else begin
            bus.acc_valid_i <= 1'b0;
            if (bus.acc_valid_o && bus.acc_run_o) begin
                acc_sum         <= acc_sum + 16'(bus.acc_number_o);
                acc_cnt         <= acc_cnt + 1;
                bus.acc_valid_i <= !(drop_en && (acc_cnt + 1 == drop_idx));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive();
        bus.dvalid_i[0] = (s0.size() > 0) && (!toggle_en || phase);
        bus.dvalid_i[1] = (s1.size() > 0) && (!toggle_en || phase);
        bus.data0_i     = (s0.size() > 0) ? s0[0] : 8'd0;
        bus.data1_i     = (s1.size() > 0) ? s1[0] : 8'd0;
    endtask

    // One clock: note handshakes before the edge, sample 1ns after it,
    // score done pulses, then drive the next inputs.
    task automatic cycle();
        logic x0, x1;
        exp_t e;
        x0 = reset_n & bus.dvalid_i[0] & bus.dready_o[0];
        x1 = reset_n & bus.dvalid_i[1] & bus.dready_o[1];
        @(posedge clk);
        #1;
        cyc++;
        if (x0 && s0.size() > 0) void'(s0.pop_front());
        if (x1 && s1.size() > 0) void'(s1.pop_front());
        phase = ~phase;
        if (reset_n) begin
            if (!bus.acc_reset_n_o) clr_cnt++;
            if (bus.acc_run_o && bus.dready_o == 2'b00) drain_cnt++;
            if (bus.dready_o[1]) dr1_seen = 1;
            if (bus.done_o != 2'b00) begin
                last_done_cyc = cyc;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(bus.done_o), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("done_o", 32'(bus.done_o), 32'(e.done));
                    chk("result_o", 32'(bus.result_o), 32'(e.res));
                    chk("err_o", 32'(bus.err_o), 32'(e.err));
                end
                if (bus.done_o[0]) bus.req_i[0] = 1'b0;
                if (bus.done_o[1]) bus.req_i[1] = 1'b0;
            end
        end
        drive();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_until_empty(input string tag, input int budget);
        int n;
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            cycle();
            n++;
        end
        if (sb.size() > 0) chk({tag, "_timeout"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic push_exp(input logic [1:0] d, input logic [15:0] r, input logic er);
        exp_t e;
        e.done = d;
        e.res  = r;
        e.err  = er;
        sb.push_back(e);
    endtask

    task automatic clear_stats();
        clr_cnt   = 0;
        drain_cnt = 0;
        dr1_seen  = 0;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        bus.req_i  = 2'b00;
        sb.delete();
        s0.delete();
        s1.delete();
        cycle();
        cycle();
        reset_n = 1'b1;
        cycle();
    endtask

    initial begin
        int n;
        int start_cyc;
        reset_n       = 1'b0;
        bus.req_i     = 2'b00;
        bus.len0_i    = 8'd0;
        bus.len1_i    = 8'd0;
        bus.data0_i   = 8'd0;
        bus.data1_i   = 8'd0;
        bus.dvalid_i  = 2'b00;

        // Reset state, sampled while reset_n is still low
        cycle();
        cycle();
        chk("rst_done",      32'(bus.done_o), 32'd0);
        chk("rst_result",    32'(bus.result_o), 32'd0);
        chk("rst_err",       32'(bus.err_o), 32'd0);
        chk("rst_busy",      32'(bus.busy_o), 32'd0);
        chk("rst_dready",    32'(bus.dready_o), 32'd0);
        chk("rst_acc_valid", 32'(bus.acc_valid_o), 32'd0);
        chk("rst_acc_run",   32'(bus.acc_run_o), 32'd0);
        chk("rst_acc_num",   32'(bus.acc_number_o), 32'd0);
        chk("rst_acc_rstn",  32'(bus.acc_reset_n_o), 32'd0);
        reset_n = 1'b1;
        idle(2);

        // Single burst from requester 0: 2+3+4
        clear_stats();
        s0 = '{8'd2, 8'd3, 8'd4};
        bus.len0_i = 8'd3;
        bus.req_i  = 2'b01;
        push_exp(2'b01, 16'd9, 1'b0);
        drive();
        run_until_empty("single", 100);
        chk("single_clear_cycles", 32'(clr_cnt), 32'd1);
        idle(3);

        // Both request after reset: requester 0 first, then requester 1
        do_reset();
        clear_stats();
        s0 = '{8'd1, 8'd1};
        s1 = '{8'd5, 8'd5};
        bus.len0_i = 8'd2;
        bus.len1_i = 8'd2;
        bus.req_i  = 2'b11;
        push_exp(2'b01, 16'd2, 1'b0);
        push_exp(2'b10, 16'd10, 1'b0);
        drive();
        run_until_empty("rr", 200);
        chk("rr_clear_cycles", 32'(clr_cnt), 32'd2);
        idle(3);

        // Zero-length burst from requester 1: done in the cycle after the
        // request is sampled, accumulator never cleared
        clear_stats();
        bus.len1_i = 8'd0;
        bus.req_i  = 2'b10;
        push_exp(2'b10, 16'd0, 1'b0);
        start_cyc = cyc;
        run_until_empty("zero_len", 20);
        chk("zero_len_latency", 32'(last_done_cyc - start_cyc), 32'd1);
        chk("zero_len_no_clear", 32'(clr_cnt), 32'd0);
        idle(3);

        // Last accumulator result dropped: timeout after 16 DRAIN cycles,
        // sum of all four samples still captured
        clear_stats();
        drop_en  = 1;
        drop_idx = 4;
        s0 = '{8'd1, 8'd2, 8'd3, 8'd4};
        bus.len0_i = 8'd4;
        bus.req_i  = 2'b01;
        push_exp(2'b01, 16'd10, 1'b1);
        drive();
        run_until_empty("timeout", 100);
        chk("timeout_drain_cycles", 32'(drain_cnt), 32'd16);
        drop_en = 0;
        idle(3);

        // dvalid toggling every other cycle; requester 1 never sees ready
        clear_stats();
        toggle_en = 1;
        s0 = '{8'd3, 8'd7, 8'd11, 8'd13, 8'd17};
        bus.len0_i = 8'd5;
        bus.req_i  = 2'b01;
        push_exp(2'b01, 16'd51, 1'b0);
        drive();
        run_until_empty("toggle", 100);
        chk("toggle_dready1_low", 32'(dr1_seen), 32'd0);
        toggle_en = 0;
        idle(3);

        // Reset after two of five samples: burst aborted silently
        clear_stats();
        s0 = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        bus.len0_i = 8'd5;
        bus.req_i  = 2'b01;
        drive();
        n = 0;
        while (s0.size() > 3 && n < 50) begin
            cycle();
            n++;
        end
        chk("abort_two_sent", 32'(s0.size()), 32'd3);
        reset_n   = 1'b0;
        bus.req_i = 2'b00;
        cycle();
        chk("abort_done",      32'(bus.done_o), 32'd0);
        chk("abort_busy",      32'(bus.busy_o), 32'd0);
        chk("abort_dready",    32'(bus.dready_o), 32'd0);
        chk("abort_acc_valid", 32'(bus.acc_valid_o), 32'd0);
        chk("abort_acc_run",   32'(bus.acc_run_o), 32'd0);
        chk("abort_acc_num",   32'(bus.acc_number_o), 32'd0);
        chk("abort_result",    32'(bus.result_o), 32'd0);
        chk("abort_err",       32'(bus.err_o), 32'd0);
        chk("abort_acc_rstn",  32'(bus.acc_reset_n_o), 32'd0);
        reset_n = 1'b1;
        s0.delete();
        drive();
        idle(6);
        s0 = '{8'd6, 8'd6};
        bus.len0_i = 8'd2;
        bus.req_i  = 2'b01;
        push_exp(2'b01, 16'd12, 1'b0);
        drive();
        run_until_empty("after_abort", 100);
        idle(3);

        // Maximum length burst from requester 1 must not wrap
        clear_stats();
        s1.delete();
        for (int i = 0; i < 255; i++) s1.push_back(8'd1);
        bus.len1_i = 8'd255;
        bus.req_i  = 2'b10;
        push_exp(2'b10, 16'd255, 1'b0);
        drive();
        run_until_empty("max_len", 600);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
